// File: rtl/dbus_lsu.sv
// Core-side load/store unit: one RV32I load/store at a time, issued as a single-word DBus cycle.
// Misaligned or illegal requests skip the bus and answer directly with an exception.
module dbus_lsu #(
    parameter int ADDR_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_exc,
    output logic [3:0]            resp_cause,
    output logic [31:0]           resp_addr,
    output logic                  dbus_rd_en,
    output logic                  dbus_wr_en,
    output logic [ADDR_WIDTH-1:0] dbus_addr,
    output logic [31:0]           dbus_wr_data,
    output logic [3:0]            dbus_wr_strobe,
    input  logic [31:0]           dbus_rd_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_exc;
    logic [3:0]  r_cause;

    logic        w_legal;
    logic        w_misal;
    logic        w_exc;
    logic [3:0]  w_cause;

    function automatic logic [3:0] f_strobe(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] d);
        logic [31:0] s;
        s = d >> {a, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return d;
        endcase
    endfunction

    // Illegal width code outranks misalignment when both apply.
    always_comb begin
        w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (!req_we && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
        w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_exc   = !w_legal || w_misal;
        if (!w_legal)    w_cause = 4'd2;
        else if (req_we) w_cause = 4'd6;
        else             w_cause = 4'd4;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Outputs are gated by state so the bus and response are quiet outside their phase.
    always_comb begin
        w_next         = r_state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = 32'd0;
        resp_exc       = 1'b0;
        resp_cause     = 4'd0;
        resp_addr      = 32'd0;
        dbus_rd_en     = 1'b0;
        dbus_wr_en     = 1'b0;
        dbus_addr      = '0;
        dbus_wr_data   = 32'd0;
        dbus_wr_strobe = 4'd0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = w_exc ? RESP : ACCESS;
            end
            ACCESS: begin
                dbus_addr = r_addr[ADDR_WIDTH+1:2];
                if (r_we) begin
                    dbus_wr_en     = 1'b1;
                    dbus_wr_data   = f_lanes(r_funct3, r_wdata);
                    dbus_wr_strobe = f_strobe(r_funct3, r_addr[1:0]);
                end else begin
                    dbus_rd_en = 1'b1;
                end
                w_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_exc   = r_exc;
                resp_cause = r_cause;
                resp_addr  = r_addr;
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_exc    <= w_exc;
            r_cause  <= w_exc ? w_cause : 4'd0;
            r_rdata  <= 32'd0;
        end else if (r_state == ACCESS && !r_we) begin
            r_rdata <= f_extract(r_funct3, r_addr[1:0], dbus_rd_data);
        end
    end

endmodule

// File: tb/tb_dbus_lsu.sv
// Directed bench for dbus_lsu: stores, load extraction, exceptions, backpressure and mid-access reset.
module tb_dbus_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic [3:0]  resp_cause;
    logic [31:0] resp_addr;
    logic        dbus_rd_en;
    logic        dbus_wr_en;
    logic [29:0] dbus_addr;
    logic [31:0] dbus_wr_data;
    logic [3:0]  dbus_wr_strobe;
    logic [31:0] dbus_rd_data;

    int n_chk  = 0;
    int n_pass = 0;

    dbus_lsu #(.ADDR_WIDTH(30)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_exc       (resp_exc),
        .resp_cause     (resp_cause),
        .resp_addr      (resp_addr),
        .dbus_rd_en     (dbus_rd_en),
        .dbus_wr_en     (dbus_wr_en),
        .dbus_addr      (dbus_addr),
        .dbus_wr_data   (dbus_wr_data),
        .dbus_wr_strobe (dbus_wr_strobe),
        .dbus_rd_data   (dbus_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, ".rd_en"},  {31'd0, dbus_rd_en}, 32'd0);
        chk({tag, ".wr_en"},  {31'd0, dbus_wr_en}, 32'd0);
        chk({tag, ".addr"},   {2'd0, dbus_addr},   32'd0);
        chk({tag, ".wdata"},  dbus_wr_data,        32'd0);
        chk({tag, ".strobe"}, {28'd0, dbus_wr_strobe}, 32'd0);
    endtask

    // Presents a request for one edge; afterwards the DUT is in ACCESS (legal) or RESP (exception).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd);
        req_we       = we;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        dbus_rd_data = rd;
        req_valid    = 1'b1;
        chk("accept.req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic chk_store(input string tag, input logic [29:0] wa, input logic [31:0] d,
                             input logic [3:0] s);
        chk({tag, ".wr_en"},  {31'd0, dbus_wr_en}, 32'd1);
        chk({tag, ".rd_en"},  {31'd0, dbus_rd_en}, 32'd0);
        chk({tag, ".addr"},   {2'd0, dbus_addr},   {2'd0, wa});
        chk({tag, ".wdata"},  dbus_wr_data,        d);
        chk({tag, ".strobe"}, {28'd0, dbus_wr_strobe}, {28'd0, s});
        chk({tag, ".busy_valid"}, {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic chk_resp(input string tag, input logic exc, input logic [3:0] cause,
                            input logic [31:0] rdata, input logic [31:0] a);
        chk({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, ".exc"},   {31'd0, resp_exc},   {31'd0, exc});
        chk({tag, ".cause"}, {28'd0, resp_cause}, {28'd0, cause});
        chk({tag, ".rdata"}, resp_rdata,          rdata);
        chk({tag, ".raddr"}, resp_addr,           a);
        chk({tag, ".ready"}, {31'd0, req_ready},  32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, ".done_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, ".done_raddr"}, resp_addr,          32'd0);
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0, 32'h80FF_7F01);
        chk({tag, ".rd_en"},  {31'd0, dbus_rd_en}, 32'd1);
        chk({tag, ".addr"},   {2'd0, dbus_addr},   {4'd0, a[29:2]});
        chk({tag, ".strobe"}, {28'd0, dbus_wr_strobe}, 32'd0);
        tick();
        chk_resp(tag, 1'b0, 4'd0, exp, a);
    endtask

    task automatic excp(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [3:0] cause);
        issue(we, f3, a, 32'hFFFF_FFFF, 32'h1234_5678);
        chk_bus_idle(tag);
        chk_resp(tag, 1'b1, cause, 32'd0, a);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_funct3   = 3'd0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        resp_ready   = 1'b0;
        dbus_rd_data = 32'd0;
        tick();
        tick();
        chk("rst.req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_exc",   {31'd0, resp_exc},   32'd0);
        chk("rst.resp_cause", {28'd0, resp_cause}, 32'd0);
        chk("rst.resp_rdata", resp_rdata,          32'd0);
        chk("rst.resp_addr",  resp_addr,           32'd0);
        chk_bus_idle("rst");
        rst_n = 1'b1;
        tick();

        // Stores
        issue(1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0);
        chk_store("sw", 30'd2, 32'hDEAD_BEEF, 4'b1111);
        tick();
        chk_bus_idle("sw_resp");
        chk_resp("sw", 1'b0, 4'd0, 32'd0, 32'h0000_0008);

        issue(1'b1, 3'b000, 32'h0000_0103, 32'hFFFF_FFA5, 32'h0);
        chk_store("sb", 30'h40, 32'hA5A5_A5A5, 4'b1000);
        tick();
        chk_resp("sb", 1'b0, 4'd0, 32'd0, 32'h0000_0103);

        issue(1'b1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'h0);
        chk_store("sh", 30'h40, 32'h1234_1234, 4'b1100);
        tick();
        chk_resp("sh", 1'b0, 4'd0, 32'd0, 32'h0000_0102);

        issue(1'b1, 3'b000, 32'h0000_0101, 32'h0000_003C, 32'h0);
        chk_store("sb1", 30'h40, 32'h3C3C_3C3C, 4'b0010);
        tick();
        chk_resp("sb1", 1'b0, 4'd0, 32'd0, 32'h0000_0101);

        // Loads against read data 0x80FF7F01
        load("lb1",  3'b000, 32'h0000_0041, 32'h0000_007F);
        load("lb2",  3'b000, 32'h0000_0042, 32'hFFFF_FFFF);
        load("lbu3", 3'b100, 32'h0000_0043, 32'h0000_0080);
        load("lh2",  3'b001, 32'h0000_0042, 32'hFFFF_80FF);
        load("lhu0", 3'b101, 32'h0000_0040, 32'h0000_7F01);
        load("lw0",  3'b010, 32'h0000_0040, 32'h80FF_7F01);

        // Exceptions: one cycle to response, no bus activity
        excp("lw_mis",  1'b0, 3'b010, 32'h0000_0202, 4'd4);
        excp("sh_mis",  1'b1, 3'b001, 32'h0000_0201, 4'd6);
        excp("st_ill",  1'b1, 3'b100, 32'h0000_0300, 4'd2);
        excp("ld_ill",  1'b0, 3'b011, 32'h0000_0301, 4'd2);
        excp("lhu_mis", 1'b0, 3'b101, 32'h0000_0303, 4'd4);

        // Backpressure with a competing request held on the input
        issue(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h1122_3344);
        tick();
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0050;
        req_wdata  = 32'hCAFE_F00D;
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", {31'd0, resp_valid}, 32'd1);
            chk("bp.rdata", resp_rdata,          32'h1122_3344);
            chk("bp.raddr", resp_addr,           32'h0000_0044);
            chk("bp.ready", {31'd0, req_ready},  32'd0);
            chk("bp.wr_en", {31'd0, dbus_wr_en}, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp.rel_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp.rel_ready", {31'd0, req_ready},  32'd1);
        tick();
        req_valid = 1'b0;
        chk_store("bp_next", 30'h14, 32'hCAFE_F00D, 4'b1111);
        tick();
        chk_resp("bp_next", 1'b0, 4'd0, 32'd0, 32'h0000_0050);

        // Reset during the ACCESS of a load
        issue(1'b0, 3'b010, 32'h0000_0060, 32'h0, 32'h5555_AAAA);
        chk("rstacc.rd_en", {31'd0, dbus_rd_en}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_bus_idle("rstacc");
        chk("rstacc.valid", {31'd0, resp_valid}, 32'd0);
        chk("rstacc.ready", {31'd0, req_ready},  32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstacc.no_resp", {31'd0, resp_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dbus_lsu.md
Name: dbus_lsu

Overview:
- Core-side load/store unit and the DBus initiator. It accepts one RV32I load or store at a time from the execute stage and issues a single-word DBus transaction to memory-mapped responders such as the machine timer.
- It drives byte strobes and replicated store data, then extracts and extends load data.
- Misaligned and illegal accesses are flagged as exceptions and are never placed on the bus.

Parameters:
- ADDR_WIDTH, 30, DBus word-address width; the bus address is byte address bits [ADDR_WIDTH+1:2].

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  result available
- resp_ready  in  1  writeback consumes the result
- resp_rdata  out  32  extended load data (0 for stores and exceptions)
- resp_exc  out  1  exception flag
- resp_cause  out  4  mcause code: 2 illegal, 4 load misaligned, 6 store misaligned
- resp_addr  out  32  request byte address (for mtval)
- dbus_rd_en  out  1  bus read enable
- dbus_wr_en  out  1  bus write enable
- dbus_addr  out  ADDR_WIDTH  word address
- dbus_wr_data  out  32  store data, lane-replicated
- dbus_wr_strobe  out  4  byte enables
- dbus_rd_data  in  32  responder read data, combinational in the same cycle as dbus_rd_en

Behaviour:
- FSM states are IDLE, ACCESS and RESP. Reset puts the FSM in IDLE.
- Reset values of outputs: req_ready=1; resp_valid=0; resp_exc=0; resp_cause=0; resp_rdata=0; resp_addr=0; all dbus_* outputs 0.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we, funct3, addr and wdata, then classify the request.
  - Legal and aligned: go to ACCESS.
  - Otherwise: go to RESP with resp_exc=1. No bus cycle is issued.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code gives cause 2. The illegal check takes priority over the misalignment check.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - A violation gives cause 4 for a load and cause 6 for a store.
- ACCESS (exactly one cycle):
  - dbus_addr = addr[ADDR_WIDTH+1:2].
  - Load: dbus_rd_en=1. dbus_rd_data is sampled at the end of the cycle.
  - Store: dbus_wr_en=1.
    - Byte: dbus_wr_data = {4{wdata[7:0]}}, dbus_wr_strobe = 0001<<addr[1:0].
    - Half: dbus_wr_data = {2{wdata[15:0]}}, dbus_wr_strobe = 0011<<addr[1:0].
    - Word: dbus_wr_data = wdata, dbus_wr_strobe = 1111.
  - Then go to RESP.
  - Outside ACCESS, all dbus_* outputs are 0, including addr, data and strobe.
- Load extraction:
  - s = rd_data >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15 of s.
  - LBU/LHU zero-extend s.
  - LW passes rd_data unchanged.
- RESP:
  - resp_valid=1 and resp_* are held stable until resp_ready=1.
  - On the cycle resp_ready=1, go to IDLE. resp_* return to 0 the following cycle.
- Latency:
  - Accepted legal request: resp_valid asserts 2 cycles after the accept edge (IDLE→ACCESS→RESP).
  - Exception: resp_valid asserts 1 cycle after the accept edge.
- req_ready=0 in ACCESS and RESP, so there is exactly one request in flight. A new request can be accepted in the cycle after the RESP handshake.
- Reset mid-transaction: the FSM returns to IDLE, the in-flight response is dropped, and bus enables deassert in the next cycle.
- resp_addr always equals the captured request address, including for exceptions.

Test Plan:
- Store SW addr=0x0000_0008, wdata=0xDEAD_BEEF → one ACCESS cycle with dbus_wr_en=1, dbus_addr=2, strobe=1111, data=0xDEADBEEF. resp_valid 2 cycles after accept with resp_exc=0 and resp_rdata=0.
- SB addr=0x...03, wdata=0x0000_00A5 → data=0xA5A5A5A5, strobe=1000. SH addr=0x...02, wdata=0x1234 → data=0x12341234, strobe=1100.
- Loads with dbus_rd_data=0x80FF_7F01:
  - LB @+1 → 0x0000007F.
  - LB @+2 → 0xFFFFFFFF.
  - LBU @+3 → 0x00000080.
  - LH @+2 → 0xFFFF80FF.
  - LHU @+0 → 0x00007F01.
  - LW @+0 → 0x80FF7F01.
- Misaligned and illegal requests, each giving resp_valid 1 cycle after accept, zero bus activity, and resp_addr equal to the request address:
  - LW addr=0x...02 → resp_exc=1, cause=4.
  - SH addr=0x...01 → resp_exc=1, cause=6.
  - Store funct3=100 → cause=2.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_* stable, req_ready=0, and a pending req_valid is not accepted. Release → IDLE, and the next request is accepted on the following cycle.
- Assert rst_n=0 during ACCESS of a load → next cycle all dbus_* outputs are 0, resp_valid=0, req_ready=1, and no response is ever produced for that load.
